// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_arb_pkg
// Brief    : Shared types and defaults for the register load arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam int C_DEF_NREQ  = 4;
  localparam int C_DEF_WIDTH = 12;
  localparam int C_DEF_LAT   = 2;
  localparam int GRANT_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/reg_load_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_load_arbiter_if
// Brief    : Requester/register-side bundle of the load arbiter.
//            Carries grant_cnt when REG_ARB_GRANT_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_load_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int NREQ  = C_DEF_NREQ,
  parameter int WIDTH = C_DEF_WIDTH
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  ld;
  logic [WIDTH-1:0]      pin;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic                  busy;
`ifdef REG_ARB_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] grant_cnt;
`endif

  modport master (
    output req, data,
    input
`ifdef REG_ARB_GRANT_CNT_EN
    grant_cnt,
`endif
    gnt, ld, pin, rsp_valid, rsp_id, busy
  );

  modport slave (
    input  req, data,
    output
`ifdef REG_ARB_GRANT_CNT_EN
    grant_cnt,
`endif
    gnt, ld, pin, rsp_valid, rsp_id, busy
  );

endinterface
`default_nettype wire

// File: rtl/reg_load_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first set request at or
//            above the pointer, wrapping modulo NREQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter  int NREQ = C_DEF_NREQ,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic            o_found,
  output logic [ID_W-1:0] o_idx
);

  int w_j;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (i_req[w_j[ID_W-1:0]]) begin
        o_found = 1'b1;
        o_idx   = w_j[ID_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_load_arbiter
// Brief    : Round-robin owner of a shared register's load port; one ld pulse
//            per grant, completion reported once the value reaches out.
//            Optional grant counter: define REG_ARB_GRANT_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_load_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ  = C_DEF_NREQ,
  parameter int WIDTH = C_DEF_WIDTH,
  parameter int LAT   = C_DEF_LAT
) (
  input  logic             clk,
  input  logic             rst,
  reg_load_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_ptr, w_ptr_nxt;
  logic [ID_W-1:0]  r_id, w_id_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_pin, w_pin_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic             r_ld, w_ld_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic [ID_W-1:0]  r_rsp_id, w_rsp_id_nxt;
  logic             r_busy, w_busy_nxt;

  logic             w_found;
  logic [ID_W-1:0]  w_pick;
  logic [WIDTH-1:0] w_slices [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign w_slices[g] = bus.data[g*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_id_nxt        = r_id;
    w_cnt_nxt       = r_cnt;
    w_pin_nxt       = r_pin;
    w_gnt_nxt       = '0;
    w_ld_nxt        = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_id_nxt    = r_rsp_id;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_LOAD;
          w_id_nxt    = w_pick;
          w_pin_nxt   = w_slices[w_pick];
          w_gnt_nxt   = NREQ'(1) << w_pick;
          w_ld_nxt    = 1'b1;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_SETTLE;
        w_cnt_nxt   = CNT_W'(LAT - 1);
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = (r_id == ID_W'(NREQ - 1)) ? '0 : r_id + ID_W'(1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // The response rides on the final settle cycle, when out already holds the value.
    if ((w_state_nxt == ST_SETTLE) && (w_cnt_nxt == '0)) begin
      w_rsp_valid_nxt = 1'b1;
      w_rsp_id_nxt    = r_id;
    end
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_pin       <= '0;
      r_gnt       <= '0;
      r_ld        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_id        <= w_id_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pin       <= w_pin_nxt;
      r_gnt       <= w_gnt_nxt;
      r_ld        <= w_ld_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.ld        = r_ld;
  assign bus.pin       = r_pin;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.busy      = r_busy;

`ifdef REG_ARB_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] r_grant_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_cnt <= '0;
    end else if (w_rsp_valid_nxt && (r_grant_cnt != '1)) begin
      r_grant_cnt <= r_grant_cnt + GRANT_CNT_W'(1);
    end
  end

  assign bus.grant_cnt = r_grant_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_load_arbiter
// Brief    : Directed scoreboard bench for reg_load_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_load_arbiter;
  import reg_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 12;
  localparam int LAT   = 2;
  localparam int ID_W  = 2;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_load_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  reg_load_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t gnt_q[$];
  exp_t rsp_q[$];
  int   rsp_cyc_q[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   gnt_seen = 0;
  int   rsp_seen = 0;
  int   last_gnt_cyc = -100;
  int   gnt_per_id [NREQ] = '{default: 0};
  logic prev_ld = 1'b0;

  // Model of the driven register: sync reset, ld-gated val stage, then out stage.
  logic [WIDTH-1:0] m_val, m_out;
  always @(posedge clk) begin
    if (rst) begin
      m_val <= '0;
      m_out <= '0;
    end else begin
      if (bus.ld) m_val <= bus.pin;
      m_out <= m_val;
    end
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a grant or a response.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rsp_cyc_q.delete();
      prev_ld = 1'b0;
      last_gnt_cyc = -100;
    end else begin
      if ((bus.gnt != '0) || bus.ld) begin
        gnt_seen++;
        if (gnt_q.size() == 0) begin
          check("unexpected_gnt", 32'(bus.gnt), 0);
        end else begin
          m_e = gnt_q.pop_front();
          check("gnt", 32'(bus.gnt), 32'(1) << m_e.id);
          check("ld", 32'(bus.ld), 1);
          check("pin", 32'(bus.pin), 32'(m_e.val));
          check("busy_load", 32'(bus.busy), 1);
          check("gnt_spacing", 32'(cyc - last_gnt_cyc >= LAT + 2), 1);
          gnt_per_id[m_e.id]++;
        end
        check("ld_one_cycle", 32'(prev_ld), 0);
        last_gnt_cyc = cyc;
        rsp_cyc_q.push_back(cyc + LAT);
      end
      if (bus.rsp_valid) begin
        rsp_seen++;
        check("rsp_vs_gnt", 32'(bus.gnt), 0);
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'(bus.rsp_valid), 0);
        end else begin
          m_e = rsp_q.pop_front();
          check("rsp_id", 32'(bus.rsp_id), 32'(m_e.id));
          check("reg_out", 32'(m_out), 32'(m_e.val));
          if (rsp_cyc_q.size() != 0) check("rsp_latency", cyc, rsp_cyc_q.pop_front());
          else check("rsp_latency", cyc, 0);
        end
      end
      prev_ld = bus.ld;
    end
  end

  task automatic expect_load(int id, logic [WIDTH-1:0] v, bit with_rsp);
    exp_t e;
    e.id  = ID_W'(id);
    e.val = v;
    gnt_q.push_back(e);
    if (with_rsp) rsp_q.push_back(e);
  endtask

  task automatic wait_gnts(int target);
    for (int k = 0; k < 400 && gnt_seen < target; k++) @(negedge clk);
    check("wait_gnt", 32'(gnt_seen >= target), 1);
  endtask

  task automatic wait_rsps(int target);
    for (int k = 0; k < 400 && rsp_seen < target; k++) @(negedge clk);
    check("wait_rsp", 32'(rsp_seen >= target), 1);
  endtask

  task automatic do_load(int id, logic [WIDTH-1:0] v);
    int g;
    int r;
    g = gnt_seen;
    r = rsp_seen;
    bus.data[id*WIDTH +: WIDTH] = v;
    expect_load(id, v, 1'b1);
    bus.req[id] = 1'b1;
    wait_gnts(g + 1);
    bus.req[id] = 1'b0;
    wait_rsps(r + 1);
    @(negedge clk);
  endtask

  initial begin
    int g;
    int r;
    rst = 1'b1;
    bus.req  = '0;
    bus.data = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_ld", 32'(bus.ld), 0);
    check("rst_pin", 32'(bus.pin), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fairness: all four requesting, pointer starts at 0.
    for (int i = 0; i < NREQ; i++) bus.data[i*WIDTH +: WIDTH] = 12'h5A0 | 12'(i);
    for (int n = 0; n < 12; n++) expect_load(n % NREQ, 12'h5A0 | 12'(n % NREQ), 1'b1);
    g = gnt_seen;
    r = rsp_seen;
    bus.req = 4'b1111;
    wait_gnts(g + 12);
    bus.req = '0;
    wait_rsps(r + 12);
    for (int i = 0; i < NREQ; i++) check("fair_count", gnt_per_id[i], 3);
    @(negedge clk);

    // Single request; pointer goes to 3 afterwards.
    do_load(2, 12'hABC);

    // Wrap and skip from pointer 3.
    bus.data[0*WIDTH +: WIDTH] = 12'h0A0;
    bus.data[2*WIDTH +: WIDTH] = 12'h2A2;
    expect_load(0, 12'h0A0, 1'b1);
    expect_load(2, 12'h2A2, 1'b1);
    expect_load(0, 12'h0A0, 1'b1);
    g = gnt_seen;
    r = rsp_seen;
    bus.req = 4'b0101;
    wait_gnts(g + 3);
    bus.req = '0;
    wait_rsps(r + 3);
    @(negedge clk);

    // Data changed after capture must not reach pin.
    bus.data[1*WIDTH +: WIDTH] = 12'h111;
    expect_load(1, 12'h111, 1'b1);
    g = gnt_seen;
    r = rsp_seen;
    bus.req = 4'b0010;
    @(posedge clk);
    #1 bus.data[1*WIDTH +: WIDTH] = 12'h222;
    wait_gnts(g + 1);
    bus.req = '0;
    wait_rsps(r + 1);
    @(negedge clk);

    // Reset one cycle after ld: outputs drop at once, no response follows.
    bus.data[0*WIDTH +: WIDTH] = 12'h0F0;
    bus.data[3*WIDTH +: WIDTH] = 12'h3F3;
    expect_load(0, 12'h0F0, 1'b0);
    bus.req = 4'b0001;
    for (int k = 0; k < 20 && !bus.ld; k++) @(negedge clk);
    check("ld_before_rst", 32'(bus.ld), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ld", 32'(bus.ld), 0);
    check("async_rst_gnt", 32'(bus.gnt), 0);
    check("async_rst_busy", 32'(bus.busy), 0);
    check("async_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    bus.req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // With the pointer back at 0, requester 0 wins over 3.
    expect_load(0, 12'h0F0, 1'b1);
    g = gnt_seen;
    r = rsp_seen;
    bus.req = 4'b1001;
    wait_gnts(g + 1);
    bus.req = '0;
    wait_rsps(r + 1);
    @(negedge clk);

`ifdef REG_ARB_GRANT_CNT_EN
    check("grant_cnt_after_rst", 32'(bus.grant_cnt), 1);
    do_load(1, 12'h011);
    do_load(2, 12'h022);
    do_load(3, 12'h033);
    do_load(0, 12'h044);
    check("grant_cnt_5", 32'(bus.grant_cnt), 5);
    force dut.r_grant_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_grant_cnt;
    do_load(1, 12'h055);
    do_load(2, 12'h066);
    do_load(3, 12'h077);
    check("grant_cnt_sat", 32'(bus.grant_cnt), 32'h0000FFFF);
`endif

    repeat (LAT + 4) @(negedge clk);
    check("gnt_q_drained", gnt_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    check("idle_busy", 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
